// File: rtl/comparator_wide_sequencer_if.sv
// Requester handshake plus shared comparator-slice bus for comparator_wide_sequencer.
// The sequencer takes the slave side; the requester/slice environment takes the master side.
interface comparator_wide_sequencer_if #(
  parameter int WORD_WIDTH = 16,
  parameter int NUM_WORDS  = 4,
  parameter int CNT_W      = $clog2(NUM_WORDS + 1)
);
  logic                            Start_In;
  logic [WORD_WIDTH*NUM_WORDS-1:0] Data_A_In;
  logic [WORD_WIDTH*NUM_WORDS-1:0] Data_B_In;
  logic                            Busy_Out;
  logic                            Done_Out;
  logic                            A_gt_B_Out;
  logic                            A_eq_B_Out;
  logic                            A_lt_B_Out;
  logic                            Error_Out;
  logic [CNT_W-1:0]                Compare_Count_Out;
  logic                            Cmp_Enable_Out;
  logic [WORD_WIDTH-1:0]           Cmp_Data_A_Out;
  logic [WORD_WIDTH-1:0]           Cmp_Data_B_Out;
  logic                            Cmp_A_gt_B_In;
  logic                            Cmp_A_eq_B_In;
  logic                            Cmp_A_lt_B_In;

  modport slave (
    input  Start_In, Data_A_In, Data_B_In,
    input  Cmp_A_gt_B_In, Cmp_A_eq_B_In, Cmp_A_lt_B_In,
    output Busy_Out, Done_Out, A_gt_B_Out, A_eq_B_Out, A_lt_B_Out,
    output Error_Out, Compare_Count_Out,
    output Cmp_Enable_Out, Cmp_Data_A_Out, Cmp_Data_B_Out
  );

  modport master (
    output Start_In, Data_A_In, Data_B_In,
    output Cmp_A_gt_B_In, Cmp_A_eq_B_In, Cmp_A_lt_B_In,
    input  Busy_Out, Done_Out, A_gt_B_Out, A_eq_B_Out, A_lt_B_Out,
    input  Error_Out, Compare_Count_Out,
    input  Cmp_Enable_Out, Cmp_Data_A_Out, Cmp_Data_B_Out
  );
endinterface

// File: rtl/comparator_wide_sequencer.sv
// Wide unsigned magnitude compare through one shared external word slice,
// walking most-significant word first and stopping at the first unequal word.
module comparator_wide_sequencer #(
  parameter int WORD_WIDTH = 16,
  parameter int NUM_WORDS  = 4,
  parameter int CNT_W      = $clog2(NUM_WORDS + 1)
) (
  input logic                        Clk_In,
  input logic                        Reset_n_In,
  comparator_wide_sequencer_if.slave bus
);
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;
  typedef enum logic [1:0] {CLS_GT, CLS_LT, CLS_EQ, CLS_ERR} cls_t;

  // Anything that is not strictly one-hot (000, 111, X, Z, ...) is an error.
  function automatic cls_t classify(input logic [2:0] flags);
    case (flags)
      3'b100:  classify = CLS_GT;
      3'b001:  classify = CLS_LT;
      3'b010:  classify = CLS_EQ;
      default: classify = CLS_ERR;
    endcase
  endfunction

  state_t                                state, state_nxt;
  logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] shadow_a, shadow_b;
  logic [IDX_W-1:0]                      idx;
  logic [CNT_W-1:0]                      cnt;
  logic                                  res_gt, res_eq, res_lt, res_err;
  cls_t                                  cls;
  logic                                  last_word;

  assign cls       = classify({bus.Cmp_A_gt_B_In, bus.Cmp_A_eq_B_In, bus.Cmp_A_lt_B_In});
  assign last_word = (idx == '0);

  always_ff @(posedge Clk_In) begin
    if (!Reset_n_In) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.Start_In) state_nxt = COMPARE;
      COMPARE: begin
        if (cls != CLS_EQ || last_word) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.Busy_Out       = (state != IDLE);
    bus.Done_Out       = (state == DONE);
    bus.Cmp_Enable_Out = (state == COMPARE);
    bus.Cmp_Data_A_Out = '0;
    bus.Cmp_Data_B_Out = '0;
    if (state == COMPARE) begin
      bus.Cmp_Data_A_Out = shadow_a[idx];
      bus.Cmp_Data_B_Out = shadow_b[idx];
    end
  end

  // Shadow operands, word walk and held result.
  always_ff @(posedge Clk_In) begin
    if (!Reset_n_In) begin
      shadow_a <= '0;
      shadow_b <= '0;
      idx      <= '0;
      cnt      <= '0;
      res_gt   <= 1'b0;
      res_eq   <= 1'b0;
      res_lt   <= 1'b0;
      res_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start_In) begin
            shadow_a <= bus.Data_A_In;
            shadow_b <= bus.Data_B_In;
            idx      <= IDX_W'(NUM_WORDS - 1);
            cnt      <= '0;
            res_gt   <= 1'b0;
            res_eq   <= 1'b0;
            res_lt   <= 1'b0;
            res_err  <= 1'b0;
          end
        end
        COMPARE: begin
          cnt <= cnt + CNT_W'(1);
          case (cls)
            CLS_GT:  res_gt <= 1'b1;
            CLS_LT:  res_lt <= 1'b1;
            CLS_EQ: begin
              if (last_word) res_eq <= 1'b1;
              else           idx    <= idx - IDX_W'(1);
            end
            default: res_err <= 1'b1;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign bus.A_gt_B_Out        = res_gt;
  assign bus.A_eq_B_Out        = res_eq;
  assign bus.A_lt_B_Out        = res_lt;
  assign bus.Error_Out         = res_err;
  assign bus.Compare_Count_Out = cnt;
endmodule

// File: tb/tb_comparator_wide_sequencer.sv
// Directed bench for comparator_wide_sequencer with a behavioural slice model
// that can be made to return non-one-hot flags for one chosen word.
module tb_comparator_wide_sequencer;
  localparam int WORD_WIDTH = 16;
  localparam int NUM_WORDS  = 4;
  localparam int CNT_W      = $clog2(NUM_WORDS + 1);

  logic clk;
  logic rst_n;
  logic fault_on;
  int   n_chk;
  int   n_pass;
  logic [15:0] seq_a[$];

  comparator_wide_sequencer_if #(
    .WORD_WIDTH(WORD_WIDTH), .NUM_WORDS(NUM_WORDS), .CNT_W(CNT_W)
  ) bus ();

  comparator_wide_sequencer #(
    .WORD_WIDTH(WORD_WIDTH), .NUM_WORDS(NUM_WORDS), .CNT_W(CNT_W)
  ) dut (
    .Clk_In     (clk),
    .Reset_n_In (rst_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slice: plain unsigned compare, or 000 on the word 0x2222 when the fault is on.
  always_comb begin
    bus.Cmp_A_gt_B_In = (bus.Cmp_Data_A_Out >  bus.Cmp_Data_B_Out);
    bus.Cmp_A_eq_B_In = (bus.Cmp_Data_A_Out == bus.Cmp_Data_B_Out);
    bus.Cmp_A_lt_B_In = (bus.Cmp_Data_A_Out <  bus.Cmp_Data_B_Out);
    if (fault_on && bus.Cmp_Enable_Out && bus.Cmp_Data_A_Out == 16'h2222) begin
      bus.Cmp_A_gt_B_In = 1'b0;
      bus.Cmp_A_eq_B_In = 1'b0;
      bus.Cmp_A_lt_B_In = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [63:0] a, input logic [63:0] b, input bit hold);
    bus.Data_A_In = a;
    bus.Data_B_In = b;
    bus.Start_In  = 1'b1;
    tick();
    if (!hold) bus.Start_In = 1'b0;
  endtask

  // Cycle 1 is the cycle right after the accept edge; lat=0 means Done never came.
  task automatic wait_done(output int lat);
    lat = 0;
    seq_a.delete();
    for (int i = 1; i <= 20; i++) begin
      if (bus.Cmp_Enable_Out) seq_a.push_back(bus.Cmp_Data_A_Out);
      if (bus.Done_Out) begin
        lat = i;
        break;
      end
      tick();
    end
  endtask

  task automatic check_result(input string t, input int lat, input int lat_exp,
                              input logic gt, input logic eq, input logic lt,
                              input logic err, input int cnt);
    chk({t, "_latency"}, 32'(lat), 32'(lat_exp));
    chk({t, "_gt"},  32'(bus.A_gt_B_Out), 32'(gt));
    chk({t, "_eq"},  32'(bus.A_eq_B_Out), 32'(eq));
    chk({t, "_lt"},  32'(bus.A_lt_B_Out), 32'(lt));
    chk({t, "_err"}, 32'(bus.Error_Out),  32'(err));
    chk({t, "_cnt"}, 32'(bus.Compare_Count_Out), 32'(cnt));
  endtask

  task automatic check_all_zero(input string t);
    chk({t, "_busy"}, 32'(bus.Busy_Out), 32'd0);
    chk({t, "_done"}, 32'(bus.Done_Out), 32'd0);
    chk({t, "_flags"}, 32'({bus.A_gt_B_Out, bus.A_eq_B_Out, bus.A_lt_B_Out}), 32'd0);
    chk({t, "_err"}, 32'(bus.Error_Out), 32'd0);
    chk({t, "_cnt"}, 32'(bus.Compare_Count_Out), 32'd0);
    chk({t, "_en"}, 32'(bus.Cmp_Enable_Out), 32'd0);
    chk({t, "_cmpa"}, 32'(bus.Cmp_Data_A_Out), 32'd0);
    chk({t, "_cmpb"}, 32'(bus.Cmp_Data_B_Out), 32'd0);
  endtask

  initial begin
    int lat;
    logic saw_done;
    n_chk = 0;
    n_pass = 0;
    fault_on = 1'b0;
    rst_n = 1'b0;
    bus.Start_In = 1'b0;
    bus.Data_A_In = '0;
    bus.Data_B_In = '0;
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // 1: top word decides, one compare
    start_op(64'h0001_0000_0000_0000, 64'h0000_FFFF_FFFF_FFFF, 1'b0);
    chk("t1_busy", 32'(bus.Busy_Out), 32'd1);
    wait_done(lat);
    check_result("t1", lat, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    tick();
    chk("t1_done_pulse", 32'(bus.Done_Out), 32'd0);
    chk("t1_idle", 32'(bus.Busy_Out), 32'd0);
    tick();
    chk("t1_hold_gt", 32'(bus.A_gt_B_Out), 32'd1);
    chk("t1_hold_cnt", 32'(bus.Compare_Count_Out), 32'd1);

    // 2: equal operands walk all words MSW first
    start_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0);
    wait_done(lat);
    check_result("t2", lat, 5, 1'b0, 1'b1, 1'b0, 1'b0, 4);
    chk("t2_seq_len", 32'(seq_a.size()), 32'd4);
    if (seq_a.size() == 4) begin
      chk("t2_seq0", 32'(seq_a[0]), 32'h1234);
      chk("t2_seq1", 32'(seq_a[1]), 32'h5678);
      chk("t2_seq2", 32'(seq_a[2]), 32'h9ABC);
      chk("t2_seq3", 32'(seq_a[3]), 32'hDEF0);
    end
    tick();

    // 3: LSW decides, then back-to-back start the cycle after Done
    start_op(64'h1111_2222_3333_4443, 64'h1111_2222_3333_4444, 1'b0);
    wait_done(lat);
    check_result("t3a", lat, 5, 1'b0, 1'b0, 1'b1, 1'b0, 4);
    tick();
    start_op(64'hFFFF_0000_0000_0000, 64'h0, 1'b0);
    wait_done(lat);
    check_result("t3b", lat, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    tick();

    // 4: Start held high, operands changed after accept
    start_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1);
    bus.Data_A_In = 64'h0;
    bus.Data_B_In = 64'h1;
    wait_done(lat);
    check_result("t4a", lat, 5, 1'b0, 1'b1, 1'b0, 1'b0, 4);
    tick();
    chk("t4_no_accept_in_done", 32'(bus.Busy_Out), 32'd0);
    tick();
    chk("t4_accept_after", 32'(bus.Busy_Out), 32'd1);
    bus.Start_In = 1'b0;
    wait_done(lat);
    check_result("t4b", lat, 5, 1'b0, 1'b0, 1'b1, 1'b0, 4);
    tick();

    // 5: reset during the second compare cycle
    start_op(64'h0000_0000_0000_0005, 64'h0000_0000_0000_0005, 1'b0);
    tick();
    chk("t5_busy_before", 32'(bus.Busy_Out), 32'd1);
    rst_n = 1'b0;
    tick();
    check_all_zero("t5_rst");
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.Done_Out) saw_done = 1'b1;
      tick();
    end
    chk("t5_no_done", 32'(saw_done), 32'd0);
    start_op(64'h0000_0000_0000_0005, 64'h0000_0000_0000_0003, 1'b0);
    wait_done(lat);
    check_result("t5b", lat, 5, 1'b1, 1'b0, 1'b0, 1'b0, 4);
    tick();

    // 6: slice returns 000 on the second word
    fault_on = 1'b1;
    start_op(64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444, 1'b0);
    wait_done(lat);
    check_result("t6", lat, 3, 1'b0, 1'b0, 1'b0, 1'b1, 2);
    fault_on = 1'b0;
    tick();
    tick();
    chk("t6_hold_err", 32'(bus.Error_Out), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
